// File: rtl/key_code_encoder_if.sv
// key_code_encoder_if
//   Bundles the key-event input and display-code outputs of key_code_encoder.
//   master : key source side (drives key events, observes the display state)
//   slave  : key_code_encoder side
//   Signals:
//     key_valid   one-cycle strobe, key_code/key_down valid
//     key_code    9-bit PS/2 scan code, bit8 = E0 prefix seen
//     key_down    1 = make, 0 = break
//     disp_codes  4*DIGITS display buffer, [3:0] = newest digit
//     code_out    last accepted code
//     code_valid  one-cycle pulse per accepted code key
//     digit_cnt   non-blank digits entered, saturating at DIGITS
interface key_code_encoder_if #(
  parameter int DIGITS = 4
);
  logic                  key_valid;
  logic [8:0]            key_code;
  logic                  key_down;
  logic [4*DIGITS-1:0]   disp_codes;
  logic [3:0]            code_out;
  logic                  code_valid;
  logic [2:0]            digit_cnt;

  modport master (
    output key_valid, key_code, key_down,
    input  disp_codes, code_out, code_valid, digit_cnt
  );

  modport slave (
    input  key_valid, key_code, key_down,
    output disp_codes, code_out, code_valid, digit_cnt
  );
endinterface

// File: rtl/key_code_encoder.sv
// key_code_encoder
//   Maps PS/2 make/break events to 4-bit seven-segment display codes
//   (0-9 digit, 10 add, 11 mul, 12 sub, 15 neg, 14 blank) and shifts
//   accepted codes into a DIGITS-deep display buffer. Enter clears the
//   buffer, Backspace drops the newest digit. Typematic repeats of the held
//   key are suppressed; a make of a different key while one is held is
//   accepted (rollover).
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    key_code_encoder_if.slave (key events in, display state out)
//   Configuration:
//     NEG_KEY_EN  when defined, top-row minus (scan 4E) produces code 15.
//                 Undefined (default): 4E is ignored.
module key_code_encoder #(
  parameter int         DIGITS     = 4,
  parameter logic [3:0] BLANK_CODE = 4'd14
) (
  input logic               clk,
  input logic               rst_n,
  key_code_encoder_if.slave bus
);

  localparam int         W       = 4 * DIGITS;
  localparam logic [2:0] CNT_MAX = 3'(DIGITS);

  typedef enum logic [1:0] {A_NONE, A_CODE, A_BACK, A_CLEAR} act_t;
  typedef struct packed {
    act_t       act;
    logic [3:0] code;
  } key_map_t;
  typedef enum logic {IDLE, HELD} state_t;

  state_t     state, state_nxt;
  logic [8:0] held_key, held_key_nxt;
  logic [W-1:0] disp, disp_nxt;
  logic [3:0] code_q, code_nxt;
  logic       code_vld, code_vld_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       take;
  key_map_t   km;

  // Scan-code decode. Only Enter is recognised with the E0 prefix; every
  // other E0-prefixed code falls to default and is ignored.
  always_comb begin
    km.act  = A_NONE;
    km.code = BLANK_CODE;
    case (bus.key_code)
      9'h045, 9'h070: begin km.act = A_CODE; km.code = 4'd0;  end
      9'h016, 9'h069: begin km.act = A_CODE; km.code = 4'd1;  end
      9'h01E, 9'h072: begin km.act = A_CODE; km.code = 4'd2;  end
      9'h026, 9'h07A: begin km.act = A_CODE; km.code = 4'd3;  end
      9'h025, 9'h06B: begin km.act = A_CODE; km.code = 4'd4;  end
      9'h02E, 9'h073: begin km.act = A_CODE; km.code = 4'd5;  end
      9'h036, 9'h074: begin km.act = A_CODE; km.code = 4'd6;  end
      9'h03D, 9'h06C: begin km.act = A_CODE; km.code = 4'd7;  end
      9'h03E, 9'h075: begin km.act = A_CODE; km.code = 4'd8;  end
      9'h046, 9'h07D: begin km.act = A_CODE; km.code = 4'd9;  end
      9'h079:         begin km.act = A_CODE; km.code = 4'd10; end
      9'h07C:         begin km.act = A_CODE; km.code = 4'd11; end
      9'h07B:         begin km.act = A_CODE; km.code = 4'd12; end
`ifdef NEG_KEY_EN
      9'h04E:         begin km.act = A_CODE; km.code = 4'd15; end
`endif
      9'h05A, 9'h15A: km.act = A_CLEAR;
      9'h066:         km.act = A_BACK;
      default: ;
    endcase
  end

  // Next-state / datapath
  always_comb begin
    state_nxt    = state;
    held_key_nxt = held_key;
    disp_nxt     = disp;
    code_nxt     = code_q;
    code_vld_nxt = 1'b0;
    cnt_nxt      = cnt;
    take         = 1'b0;

    if (state == IDLE) begin
      // Breaks in IDLE are stray releases and are dropped.
      if (bus.key_valid && bus.key_down && km.act != A_NONE) begin
        take      = 1'b1;
        state_nxt = HELD;
      end
    end else begin
      if (bus.key_valid) begin
        if (bus.key_down) begin
          // Same key again is typematic repeat; a different key is rollover.
          if (km.act != A_NONE && bus.key_code != held_key) take = 1'b1;
        end else if (bus.key_code == held_key) begin
          state_nxt = IDLE;
        end
      end
    end

    if (take) begin
      held_key_nxt = bus.key_code;
      case (km.act)
        A_CODE: begin
          disp_nxt     = {disp[W-5:0], km.code};
          code_nxt     = km.code;
          code_vld_nxt = 1'b1;
          if (cnt != CNT_MAX) cnt_nxt = cnt + 3'd1;
        end
        A_BACK: begin
          if (cnt != 3'd0) begin
            disp_nxt = {BLANK_CODE, disp[W-1:4]};
            cnt_nxt  = cnt - 3'd1;
          end
        end
        A_CLEAR: begin
          disp_nxt = {DIGITS{BLANK_CODE}};
          code_nxt = BLANK_CODE;
          cnt_nxt  = 3'd0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      held_key <= 9'd0;
      disp     <= {DIGITS{BLANK_CODE}};
      code_q   <= BLANK_CODE;
      code_vld <= 1'b0;
      cnt      <= 3'd0;
    end else begin
      state    <= state_nxt;
      held_key <= held_key_nxt;
      disp     <= disp_nxt;
      code_q   <= code_nxt;
      code_vld <= code_vld_nxt;
      cnt      <= cnt_nxt;
    end
  end

  assign bus.disp_codes = disp;
  assign bus.code_out   = code_q;
  assign bus.code_valid = code_vld;
  assign bus.digit_cnt  = cnt;

endmodule
